aes_dec_arbiter: RTL and testbench
==================================

Name: aes_dec_arbiter

Overview:
- Round-robin arbiter and job sequencer that shares one AES_Decryptor instance among NUM_REQ requesters.
- Accepts 128-bit ciphertext jobs and captures each winner's CT.
- Drives the decryptor En/CT, waits for its Ry with a watchdog, captures PT and returns it to the owning requester with a one-cycle Done pulse.
- Sits between the host-side request ports and the AES_Decryptor top. The key path is untouched; Key and SelKey stay wired directly to the key store.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 255: max cycles in RUN waiting for DecRy before abort, 1..65535.
- CW, 16: watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  reset, synchronous and active-low.
- Req  in  NUM_REQ  per-requester job request (level).
- CT_in  in  NUM_REQ*128  ciphertext; slice i = CT_in[128*i+127:128*i].
- Gnt  out  NUM_REQ  one-hot owner of current job; zero when idle.
- Done  out  NUM_REQ  one-cycle completion pulse to owner.
- PT_out  out  128  plaintext of the last completed job.
- Err  out  1  high with Done when the job timed out.
- Busy  out  1  high in any state except IDLE.
- DecEn  out  1  drives AES_Decryptor En.
- DecCT  out  128  drives AES_Decryptor CT.
- DecRy  in  1  AES_Decryptor Ry.
- DecPT  in  128  AES_Decryptor PT.

Behaviour:
- Reset (Rst=0 at a rising edge):
  - state=IDLE.
  - Gnt=0, Done=0, PT_out=0, Err=0, Busy=0, DecEn=0, DecCT=0.
  - Round-robin pointer=0, watchdog=0.
  - Reset mid-job aborts silently: no Done pulse, DecEn drops on the same edge.
- States: IDLE, RUN, RESP, GAP. All outputs are registered.
- IDLE:
  - If Req!=0, the winner is the first set bit searching upward from the pointer, wrapping NUM_REQ-1 to 0.
  - On that edge: DecCT<=CT_in slice of winner, Gnt<=onehot(winner), DecEn<=1, watchdog<=0, go RUN.
- RUN:
  - DecEn held high, watchdog increments every cycle.
  - If DecRy=1: PT_out<=DecPT, Err<=0, DecEn<=0, go RESP.
  - Else if watchdog==TIMEOUT-1: PT_out<=0, Err<=1, DecEn<=0, go RESP.
  - DecRy wins if it coincides with timeout.
- RESP (1 cycle):
  - Done<=Gnt (one cycle); Err valid.
  - Pointer<=(owner+1) mod NUM_REQ; go GAP.
- GAP (1 cycle):
  - Gnt<=0, Done<=0, Err<=0; DecEn stays 0 so the decryptor FSM re-arms.
  - Go IDLE.
- Latency: Req sampled at edge 0 gives DecEn=1 after edge 0. DecRy sampled at edge k gives Done high during cycle k+1. Next grant is possible at edge k+3.
- PT_out holds its value until the next RESP or reset.
- Requester contract:
  - Hold Req and CT_in stable from assertion until Done.
  - Dropping Req after grant is ignored: the job completes and Done still pulses.
  - Dropping Req before grant withdraws the request.
  - Req still high in IDLE after own Done is a new job; the pointer has moved past it, so other pending requesters win first.
- CT_in changes after capture have no effect on DecCT.
- DecRy outside RUN is ignored.

Test Plan:
- Single job: Req=0001, CT_in[0]=69c4e0d86a7b0430d8cdb78070b4c55a, decryptor key 000102..0f -> DecEn for the decryptor's run, Done=0001 one cycle, PT_out=00112233445566778899aabbccddeeff, Err=0.
- Contention: Req=1111 held, each requester drops Req after its Done -> grant order 0,1,2,3; pointer wraps; four Done pulses, no gaps shorter than 1 GAP cycle between DecEn periods.
- Fairness: Req=0011 with requester 0 re-asserting immediately after each Done -> grants alternate 0,1,0,1.
- Timeout: TIMEOUT=20, DecRy tied 0 -> DecEn high exactly 20 cycles, then Done pulse with Err=1, PT_out=0; next request is served normally.
- DecRy coincident with timeout cycle -> Err=0, PT_out=DecPT.
- Reset mid-RUN: Rst=0 for one cycle -> DecEn=0, Gnt=0, Busy=0, no Done; a subsequent Req=0100 is granted to requester 2 (pointer back at 0).

Source files
------------

// File: rtl/aes_dec_arbiter.sv
// Round-robin arbiter and job sequencer that shares one AES decryptor among NUM_REQ requesters.
// Captures the winner's ciphertext, runs the decryptor under a watchdog and returns plaintext with a Done pulse.
module aes_dec_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255,
    parameter int CW      = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [NUM_REQ-1:0]     Req,
    input  logic [NUM_REQ*128-1:0] CT_in,
    output logic [NUM_REQ-1:0]     Gnt,
    output logic [NUM_REQ-1:0]     Done,
    output logic [127:0]           PT_out,
    output logic                   Err,
    output logic                   Busy,
    output logic                   DecEn,
    output logic [127:0]           DecCT,
    input  logic                   DecRy,
    input  logic [127:0]           DecPT
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2, GAP = 2'd3} state_t;

    state_t               state_r, state_s;
    logic [PW-1:0]        ptr_r, ptr_s, owner_r, owner_s;
    logic [CW-1:0]        wdog_r, wdog_s;
    logic [NUM_REQ-1:0]   gnt_r, gnt_s, done_r, done_s;
    logic [127:0]         pt_r, pt_s, decct_r, decct_s;
    logic                 err_r, err_s, decen_r, decen_s, busy_r, busy_s;
    logic                 win_found_s;
    logic [PW-1:0]        win_idx_s;

    // Advance a requester index with wrap from NUM_REQ-1 back to 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(NUM_REQ - 1)) begin
            return PW'(0);
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Winner search: first set Req bit at or above the pointer, wrapping around.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = PW'(0);
        for (int k = 0; k < NUM_REQ; k++) begin
            int cand;
            cand = (int'(ptr_r) + k) % NUM_REQ;
            if (!win_found_s && Req[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = PW'(cand);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic for the job sequencer.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        owner_s = owner_r;
        wdog_s  = wdog_r;
        gnt_s   = gnt_r;
        done_s  = done_r;
        pt_s    = pt_r;
        decct_s = decct_r;
        err_s   = err_r;
        decen_s = decen_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    decct_s = CT_in[int'(win_idx_s)*128 +: 128];
                    gnt_s   = NUM_REQ'(1) << win_idx_s;
                    owner_s = win_idx_s;
                    decen_s = 1'b1;
                    wdog_s  = CW'(0);
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                wdog_s = wdog_r + CW'(1);
                // A ready on the final watchdog cycle still counts as success.
                if (DecRy) begin
                    pt_s    = DecPT;
                    err_s   = 1'b0;
                    decen_s = 1'b0;
                    state_s = RESP;
                end else if (wdog_r == WD_LAST) begin
                    pt_s    = 128'd0;
                    err_s   = 1'b1;
                    decen_s = 1'b0;
                    state_s = RESP;
                end else begin
                    state_s = RUN;
                end
            end
            RESP: begin
                done_s  = gnt_r;
                ptr_s   = ptr_inc(owner_r);
                state_s = GAP;
            end
            GAP: begin
                gnt_s   = {NUM_REQ{1'b0}};
                done_s  = {NUM_REQ{1'b0}};
                err_s   = 1'b0;
                decen_s = 1'b0;
                state_s = IDLE;
            end
            default: begin
                gnt_s   = {NUM_REQ{1'b0}};
                done_s  = {NUM_REQ{1'b0}};
                err_s   = 1'b0;
                decen_s = 1'b0;
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r <= IDLE;
            ptr_r   <= PW'(0);
            owner_r <= PW'(0);
            wdog_r  <= CW'(0);
            gnt_r   <= {NUM_REQ{1'b0}};
            done_r  <= {NUM_REQ{1'b0}};
            pt_r    <= 128'd0;
            decct_r <= 128'd0;
            err_r   <= 1'b0;
            decen_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            owner_r <= owner_s;
            wdog_r  <= wdog_s;
            gnt_r   <= gnt_s;
            done_r  <= done_s;
            pt_r    <= pt_s;
            decct_r <= decct_s;
            err_r   <= err_s;
            decen_r <= decen_s;
            busy_r  <= busy_s;
        end
    end

    assign Gnt    = gnt_r;
    assign Done   = done_r;
    assign PT_out = pt_r;
    assign Err    = err_r;
    assign Busy   = busy_r;
    assign DecEn  = decen_r;
    assign DecCT  = decct_r;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Scoreboard bench for aes_dec_arbiter: a stand-in decryptor answers with table plaintexts,
// stimulus pushes expected completions, a monitor pops and compares on every Done pulse.
module tb_aes_dec_arbiter;

    localparam int N = 4;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [N-1:0]     Req;
    logic [N*128-1:0] CT_in;
    logic [N-1:0]     Gnt, Done;
    logic [127:0]     PT_out, DecCT, DecPT;
    logic             Err, Busy, DecEn, DecRy;

    aes_dec_arbiter #(.NUM_REQ(N), .TIMEOUT(20), .CW(16)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .CT_in(CT_in), .Gnt(Gnt), .Done(Done),
        .PT_out(PT_out), .Err(Err), .Busy(Busy), .DecEn(DecEn), .DecCT(DecCT),
        .DecRy(DecRy), .DecPT(DecPT)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [N-1:0] mask;
        logic [127:0] pt;
        logic         err;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   lat = 12;        // decryptor latency in cycles; 0 means never ready
    int   lastEnLen = 0;

    logic [127:0] ctTab [0:3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                  128'h3ad77bb40d7a3660a89ecaf32466ef97,
                                  128'hf5d3d58503b9699de785895a96fdbaaf,
                                  128'h43b1cd7f598ece23881b00e3ed030688};
    logic [127:0] ptTab [0:3] = '{128'h00112233445566778899aabbccddeeff,
                                  128'h6bc1bee22e409f96e93d7e117393172a,
                                  128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                  128'h30c81c46a35ce411e5fbc1191a0a52ef};

    function automatic logic [127:0] decModel(input logic [127:0] c);
        for (int i = 0; i < 4; i++)
            if (c == ctTab[i]) return ptTab[i];
        return 128'd0;
    endfunction

    // Stand-in decryptor: raises Ry for one cycle after lat cycles of En.
    initial begin
        int cnt;
        cnt = 0; DecRy = 1'b0; DecPT = 128'd0;
        forever begin
            @(negedge Clk);
            if (DecEn) begin
                cnt++;
                if (lat != 0 && cnt == lat) begin
                    DecRy = 1'b1;
                    DecPT = decModel(DecCT);
                end else DecRy = 1'b0;
            end else begin
                cnt = 0;
                DecRy = 1'b0;
            end
        end
    end

    // Monitor: compares every Done pulse against the scoreboard.
    initial begin
        logic [N-1:0] prevDone;
        logic         prevEn, sawRun;
        int           enLen, lowLen;
        exp_t         e;
        prevDone = '0; prevEn = 1'b0; sawRun = 1'b0; enLen = 0; lowLen = 0;
        forever begin
            @(negedge Clk);
            if (DecEn) begin
                if (!prevEn && sawRun) begin
                    checks++;
                    if (lowLen < 3) begin
                        errors++;
                        $display("FAIL en_gap low_cycles=%0d need>=3", lowLen);
                    end
                end
                sawRun = 1'b1; enLen++; lowLen = 0;
            end else begin
                if (prevEn) lastEnLen = enLen;
                enLen = 0; lowLen++;
            end
            prevEn = DecEn;
            if (prevDone != '0) begin
                checks++;
                if (Done != '0) begin
                    errors++;
                    $display("FAIL done_width done=%b held two cycles", Done);
                end
            end
            if (Done != '0) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done done=%b", Done);
                end else begin
                    e = expQ.pop_front();
                    if (Done !== e.mask || Gnt !== e.mask || PT_out !== e.pt || Err !== e.err || Busy !== 1'b1) begin
                        errors++;
                        $display("FAIL done_resp got done=%b gnt=%b pt=%h err=%b busy=%b want done=%b pt=%h err=%b busy=1",
                                 Done, Gnt, PT_out, Err, Busy, e.mask, e.pt, e.err);
                    end
                end
            end
            prevDone = Done;
        end
    end

    task automatic push(input logic [N-1:0] m, input logic [127:0] p, input logic er);
        exp_t e;
        e.mask = m; e.pt = p; e.err = er;
        expQ.push_back(e);
    endtask

    task automatic checkVal(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic waitDones(input int n, input logic drop);
        int got, cyc;
        got = 0; cyc = 0;
        while (got < n && cyc < 100 * n) begin
            @(negedge Clk);
            cyc++;
            if (Done != '0) begin
                got++;
                if (drop) Req = Req & ~Done;
            end
        end
        Req = '0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL done_count got=%0d want=%0d", got, n);
        end
    endtask

    task automatic waitEn();
        int cyc;
        cyc = 0;
        while (!DecEn && cyc < 50) begin
            @(negedge Clk);
            cyc++;
        end
        checks++;
        if (!DecEn) begin
            errors++;
            $display("FAIL en_wait got=0 want=1");
        end
    endtask

    task automatic doReset();
        @(negedge Clk);
        Rst = 1'b0; Req = '0;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        Rst = 1'b0; Req = '0;
        CT_in = {ctTab[3], ctTab[2], ctTab[1], ctTab[0]};
        doReset();
        checkVal("rst_gnt",   128'(Gnt),    128'd0);
        checkVal("rst_done",  128'(Done),   128'd0);
        checkVal("rst_pt",    PT_out,       128'd0);
        checkVal("rst_err",   128'(Err),    128'd0);
        checkVal("rst_busy",  128'(Busy),   128'd0);
        checkVal("rst_decen", 128'(DecEn),  128'd0);
        checkVal("rst_decct", DecCT,        128'd0);

        // Contention: all four request, each drops after its own Done; order 0,1,2,3.
        for (int i = 0; i < N; i++) push(4'(1) << i, ptTab[i], 1'b0);
        Req = 4'b1111;
        waitDones(4, 1'b1);

        // Fairness: 0 and 1 held; grants alternate 0,1,0,1 (pointer ends at 2).
        push(4'b0001, ptTab[0], 1'b0); push(4'b0010, ptTab[1], 1'b0);
        push(4'b0001, ptTab[0], 1'b0); push(4'b0010, ptTab[1], 1'b0);
        Req = 4'b0011;
        waitDones(4, 1'b0);

        // Single job on requester 0; CT_in changes after capture must not matter.
        push(4'b0001, ptTab[0], 1'b0);
        Req = 4'b0001;
        waitEn();
        @(negedge Clk);
        CT_in[127:0] = 128'hdeadbeef_00000000_cafef00d_12345678;
        waitDones(1, 1'b0);
        checkVal("single_en_len", 128'(lastEnLen), 128'd12);
        checkVal("pt_hold", PT_out, ptTab[0]);
        CT_in[127:0] = ctTab[0];

        // Timeout: decryptor never ready.
        lat = 0;
        push(4'b0010, 128'd0, 1'b1);
        Req = 4'b0010;
        waitDones(1, 1'b0);
        checkVal("timeout_en_len", 128'(lastEnLen), 128'd20);

        // Next request after a timeout is served normally.
        lat = 12;
        push(4'b0001, ptTab[0], 1'b0);
        Req = 4'b0001;
        waitDones(1, 1'b0);

        // Ready coincident with the last watchdog cycle: success wins.
        lat = 20;
        push(4'b0100, ptTab[2], 1'b0);
        Req = 4'b0100;
        waitDones(1, 1'b0);
        checkVal("coinc_en_len", 128'(lastEnLen), 128'd20);

        // Reset in the middle of a run aborts silently.
        lat = 0;
        Req = 4'b1000;
        waitEn();
        repeat (5) @(negedge Clk);
        doReset();
        checkVal("mid_rst_decen", 128'(DecEn), 128'd0);
        checkVal("mid_rst_gnt",   128'(Gnt),   128'd0);
        checkVal("mid_rst_busy",  128'(Busy),  128'd0);
        checkVal("mid_rst_pt",    PT_out,      128'd0);
        repeat (30) @(negedge Clk);
        checkVal("mid_rst_no_done_q", 128'(expQ.size()), 128'd0);

        lat = 12;
        push(4'b0100, ptTab[2], 1'b0);
        Req = 4'b0100;
        waitEn();
        checkVal("post_rst_gnt", 128'(Gnt), 128'(4'b0100));
        waitDones(1, 1'b0);

        repeat (5) @(negedge Clk);
        checkVal("scoreboard_empty", 128'(expQ.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
